// File: rtl/mipsmorph_pkg.sv
// Shared sizing constants and helpers for the decode-stage register file.
package mipsmorph_pkg;

    localparam int DEFAULT_DW = 16;
    localparam int DEFAULT_AW = 3;

    typedef logic [DEFAULT_AW-1:0] reg_idx_t;

    function automatic int nreg(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// One pending bit per register: set at issue (reserve), cleared at writeback.
module regfile_scoreboard
    import mipsmorph_pkg::*;
#(
    parameter int AW      = DEFAULT_AW,
    parameter int NRD     = 3,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_wa,
    input  logic              i_rsv_en,
    input  logic [AW-1:0]     i_rsv_a,
    input  logic [NRD*AW-1:0] i_ra,
    output logic [NRD-1:0]    o_pend,
    output logic              o_busy_any
);

    localparam int NREG = nreg(AW);

    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_nxt;
    logic            w_wr_ok;
    logic            w_rsv_ok;

    assign w_wr_ok  = i_we     && !((ZERO_R0 != 0) && (i_wa    == '0));
    assign w_rsv_ok = i_rsv_en && !((ZERO_R0 != 0) && (i_rsv_a == '0));

    // Reserve is applied after the clear so a new producer wins over writeback.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr_ok) begin
            w_pend_nxt[i_wa] = 1'b0;
        end
        if (w_rsv_ok) begin
            w_pend_nxt[i_rsv_a] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_lookup
        assign o_pend[i] = r_pend[i_ra[i*AW +: AW]];
    end

    assign o_busy_any = |r_pend;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, single-write register file with write-through bypass, hardwired
// zero register and per-register pending scoreboard.
module regfile_sb
    import mipsmorph_pkg::*;
#(
    parameter int DW      = DEFAULT_DW,
    parameter int AW      = DEFAULT_AW,
    parameter int NRD     = 3,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] rd,
    output logic [NRD-1:0]    rbusy,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DW-1:0]     wd,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_a,
    output logic              busy_any
);

    localparam int NREG = nreg(AW);

    logic [DW-1:0]  r_regs [NREG];
    logic [NRD-1:0] w_pend;
    logic           w_wr_ok;

    assign w_wr_ok = we && !((ZERO_R0 != 0) && (wa == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREG; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[wa] <= wd;
        end
    end

    regfile_scoreboard #(
        .AW      (AW),
        .NRD     (NRD),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_we       (we),
        .i_wa       (wa),
        .i_rsv_en   (rsv_en),
        .i_rsv_a    (rsv_a),
        .i_ra       (ra),
        .o_pend     (w_pend),
        .o_busy_any (busy_any)
    );

    // A same-cycle writeback satisfies the reader only when it can be forwarded.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_zero;
        logic          w_fwd;

        assign w_ra   = ra[i*AW +: AW];
        assign w_zero = (ZERO_R0 != 0) && (w_ra == '0);
        assign w_fwd  = (BYPASS != 0) && we && (wa == w_ra);

        assign rd[i*DW +: DW] = w_zero ? {DW{1'b0}} :
                                w_fwd  ? wd         : r_regs[w_ra];
        assign rbusy[i]       = (w_zero || w_fwd) ? 1'b0 : w_pend[i];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build plus a wide, bypass-free build.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Default instance: DW=16, AW=3, NRD=3, bypass on
    logic [8:0]  ra_a;
    logic [47:0] rd_a;
    logic [2:0]  rbusy_a;
    logic        we_a;
    logic [2:0]  wa_a;
    logic [15:0] wd_a;
    logic        rsv_en_a;
    logic [2:0]  rsv_a_a;
    logic        busy_any_a;

    // Wide instance: DW=32, AW=5, NRD=4, bypass off
    logic [19:0]  ra_b;
    logic [127:0] rd_b;
    logic [3:0]   rbusy_b;
    logic         we_b;
    logic [4:0]   wa_b;
    logic [31:0]  wd_b;
    logic         rsv_en_b;
    logic [4:0]   rsv_a_b;
    logic         busy_any_b;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_sb u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .ra       (ra_a),
        .rd       (rd_a),
        .rbusy    (rbusy_a),
        .we       (we_a),
        .wa       (wa_a),
        .wd       (wd_a),
        .rsv_en   (rsv_en_a),
        .rsv_a    (rsv_a_a),
        .busy_any (busy_any_a)
    );

    regfile_sb #(
        .DW      (32),
        .AW      (5),
        .NRD     (4),
        .ZERO_R0 (1),
        .BYPASS  (0)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .ra       (ra_b),
        .rd       (rd_b),
        .rbusy    (rbusy_b),
        .we       (we_b),
        .wa       (wa_b),
        .wd       (wd_b),
        .rsv_en   (rsv_en_b),
        .rsv_a    (rsv_a_b),
        .busy_any (busy_any_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we_a = 1'b0; rsv_en_a = 1'b0;
        we_b = 1'b0; rsv_en_b = 1'b0;
    endtask

    function automatic logic [15:0] rda(input int p);
        return rd_a[p*16 +: 16];
    endfunction

    function automatic logic [31:0] rdb(input int p);
        return rd_b[p*32 +: 32];
    endfunction

    initial begin
        rst = 1'b1;
        ra_a = '0; we_a = 1'b0; wa_a = '0; wd_a = '0; rsv_en_a = 1'b0; rsv_a_a = '0;
        ra_b = '0; we_b = 1'b0; wa_b = '0; wd_b = '0; rsv_en_b = 1'b0; rsv_a_b = '0;

        // 1: reset, then every register reads zero and idle
        tick();
        rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            ra_a = {r[2:0], r[2:0], r[2:0]};
            #1;
            chk($sformatf("rst_rd0_r%0d", r), rda(0), 16'h0);
            chk($sformatf("rst_rd2_r%0d", r), rda(2), 16'h0);
            chk($sformatf("rst_rbusy_r%0d", r), rbusy_a, 3'b000);
        end
        chk("rst_busy_any", busy_any_a, 1'b0);
        ra_b = {5'd31, 5'd17, 5'd9, 5'd1};
        #1;
        chk("b_rst_rd3", rdb(3), 32'h0);
        chk("b_rst_rd1", rdb(1), 32'h0);
        chk("b_rst_busy_any", busy_any_b, 1'b0);

        // 2: bypass on r3, then registered value on all ports
        ra_a = {3'd3, 3'd3, 3'd3};
        we_a = 1'b1; wa_a = 3'd3; wd_a = 16'hBEEF;
        #1;
        chk("byp_rd0", rda(0), 16'hBEEF);
        chk("byp_rbusy", rbusy_a, 3'b000);
        tick();
        idle_inputs();
        #1;
        chk("wr_rd0", rda(0), 16'hBEEF);
        chk("wr_rd1_dup", rda(1), 16'hBEEF);
        chk("wr_rd2_dup", rda(2), 16'hBEEF);
        chk("wr_nonpend_rbusy", rbusy_a, 3'b000);

        // 3: zero register ignores write and reserve
        ra_a = {3'd3, 3'd0, 3'd3};
        we_a = 1'b1; wa_a = 3'd0; wd_a = 16'h1234;
        rsv_en_a = 1'b1; rsv_a_a = 3'd0;
        #1;
        chk("r0_byp_rd1", rda(1), 16'h0);
        chk("r0_byp_rbusy1", rbusy_a[1], 1'b0);
        tick();
        idle_inputs();
        #1;
        chk("r0_rd1", rda(1), 16'h0);
        chk("r0_rbusy1", rbusy_a[1], 1'b0);
        chk("r0_busy_any", busy_any_a, 1'b0);

        // 4: reserve r5, then writeback clears it
        rsv_en_a = 1'b1; rsv_a_a = 3'd5;
        ra_a = {3'd5, 3'd0, 3'd3};
        #1;
        chk("rsv_same_cycle_busy_any", busy_any_a, 1'b0);
        tick();
        idle_inputs();
        #1;
        chk("rsv_rbusy2", rbusy_a[2], 1'b1);
        chk("rsv_busy_any", busy_any_a, 1'b1);
        we_a = 1'b1; wa_a = 3'd5; wd_a = 16'd7;
        #1;
        chk("wb_byp_rbusy2", rbusy_a[2], 1'b0);
        chk("wb_byp_rd2", rda(2), 16'd7);
        chk("wb_byp_busy_any", busy_any_a, 1'b1);
        tick();
        idle_inputs();
        #1;
        chk("wb_rbusy2", rbusy_a[2], 1'b0);
        chk("wb_rd2", rda(2), 16'd7);
        chk("wb_busy_any", busy_any_a, 1'b0);

        // 5: write and reserve of the same pending register: new producer wins
        rsv_en_a = 1'b1; rsv_a_a = 3'd2;
        tick();
        idle_inputs();
        rsv_en_a = 1'b1; rsv_a_a = 3'd2;
        tick();
        idle_inputs();
        ra_a = {3'd5, 3'd3, 3'd2};
        #1;
        chk("rsv_twice_rbusy0", rbusy_a[0], 1'b1);
        we_a = 1'b1; wa_a = 3'd2; wd_a = 16'd9;
        rsv_en_a = 1'b1; rsv_a_a = 3'd2;
        #1;
        chk("wr_rsv_byp_rd0", rda(0), 16'd9);
        chk("wr_rsv_byp_rbusy0", rbusy_a[0], 1'b0);
        tick();
        idle_inputs();
        #1;
        chk("wr_rsv_rd0", rda(0), 16'd9);
        chk("wr_rsv_rbusy0", rbusy_a[0], 1'b1);
        chk("wr_rsv_busy_any", busy_any_a, 1'b1);

        // 6: fill r1..r7, reserve r4, then reset with a write/reserve in flight
        for (int r = 1; r < 8; r++) begin
            we_a = 1'b1; wa_a = r[2:0]; wd_a = 16'(10 + r);
            tick();
        end
        idle_inputs();
        ra_a = {3'd7, 3'd4, 3'd1};
        #1;
        chk("fill_rd0_r1", rda(0), 16'd11);
        chk("fill_rd1_r4", rda(1), 16'd14);
        chk("fill_rd2_r7", rda(2), 16'd17);
        chk("fill_r2_cleared", u_dut_a.rbusy[0] | busy_any_a, 1'b0);
        rsv_en_a = 1'b1; rsv_a_a = 3'd4;
        tick();
        idle_inputs();
        #1;
        chk("fill_rsv_rbusy1", rbusy_a[1], 1'b1);
        rst = 1'b1;
        we_a = 1'b1; wa_a = 3'd6; wd_a = 16'h00FF;
        rsv_en_a = 1'b1; rsv_a_a = 3'd1;
        tick();
        rst = 1'b0;
        idle_inputs();
        for (int r = 0; r < 8; r++) begin
            ra_a = {r[2:0], r[2:0], r[2:0]};
            #1;
            chk($sformatf("rst2_rd1_r%0d", r), rda(1), 16'h0);
            chk($sformatf("rst2_rbusy_r%0d", r), rbusy_a, 3'b000);
        end
        chk("rst2_busy_any", busy_any_a, 1'b0);

        // Wide build without bypass: same-cycle read returns the old value
        ra_b = {5'd20, 5'd31, 5'd31, 5'd9};
        we_b = 1'b1; wa_b = 5'd9; wd_b = 32'hDEADBEEF;
        #1;
        chk("b_nobyp_rd0", rdb(0), 32'h0);
        chk("b_nobyp_rbusy0", rbusy_b[0], 1'b0);
        tick();
        idle_inputs();
        #1;
        chk("b_wr_rd0", rdb(0), 32'hDEADBEEF);
        we_b = 1'b1; wa_b = 5'd31; wd_b = 32'hA5A5_0031;
        rsv_en_b = 1'b1; rsv_a_b = 5'd20;
        tick();
        idle_inputs();
        #1;
        chk("b_rd1_r31", rdb(1), 32'hA5A5_0031);
        chk("b_rd2_r31_dup", rdb(2), 32'hA5A5_0031);
        chk("b_rsv_rbusy3", rbusy_b[3], 1'b1);
        chk("b_rsv_busy_any", busy_any_b, 1'b1);
        we_b = 1'b1; wa_b = 5'd20; wd_b = 32'd5;
        #1;
        chk("b_nobyp_rbusy3", rbusy_b[3], 1'b1);
        chk("b_nobyp_rd3", rdb(3), 32'h0);
        tick();
        idle_inputs();
        #1;
        chk("b_wb_rd3", rdb(3), 32'd5);
        chk("b_wb_rbusy3", rbusy_b[3], 1'b0);
        chk("b_wb_busy_any", busy_any_b, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
